// File: rtl/axi_err_slave.sv
// AXI default slave: terminates every routed transaction with an error response
// and keeps saturating error counters plus debug capture for CSR readout.
module axi_err_slave #(
  parameter int                   ID_BITS   = 8,
  parameter int                   ADDR_BITS = 32,
  parameter int                   DATA_BITS = 32,
  parameter int                   LEN_BITS  = 4,
  parameter logic [1:0]           ERR_RESP  = 2'b11,
  parameter logic [DATA_BITS-1:0] ERR_RDATA = '0,
  parameter int                   CNT_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic [ID_BITS-1:0]     ARID,
  input  logic [ADDR_BITS-1:0]   ARADDR,
  input  logic [LEN_BITS-1:0]    ARLEN,
  input  logic [2:0]             ARSIZE,
  input  logic [1:0]             ARBURST,
  input  logic                   ARVALID,
  output logic                   ARREADY,

  output logic [ID_BITS-1:0]     RID,
  output logic [DATA_BITS-1:0]   RDATA,
  output logic [1:0]             RRESP,
  output logic                   RLAST,
  output logic                   RVALID,
  input  logic                   RREADY,

  input  logic [ID_BITS-1:0]     AWID,
  input  logic [ADDR_BITS-1:0]   AWADDR,
  input  logic [LEN_BITS-1:0]    AWLEN,
  input  logic [2:0]             AWSIZE,
  input  logic [1:0]             AWBURST,
  input  logic                   AWVALID,
  output logic                   AWREADY,

  input  logic [DATA_BITS-1:0]   WDATA,
  input  logic [DATA_BITS/8-1:0] WSTRB,
  input  logic                   WLAST,
  input  logic                   WVALID,
  output logic                   WREADY,

  output logic [ID_BITS-1:0]     BID,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,

  input  logic                   err_clr,
  output logic [CNT_BITS-1:0]    rd_err_cnt,
  output logic [CNT_BITS-1:0]    wr_err_cnt,
  output logic [ADDR_BITS-1:0]   last_err_addr,
  output logic                   wlen_mismatch
);

  localparam logic [LEN_BITS-1:0] LEN_ONE = LEN_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  r_state_t            r_state;
  w_state_t            w_state;

  logic [LEN_BITS-1:0] rlen;
  logic [LEN_BITS-1:0] rcnt;
  logic [LEN_BITS-1:0] rcnt_nxt;
  logic [LEN_BITS-1:0] wlen;
  logic [LEN_BITS-1:0] wcnt;

  logic                ar_hs;
  logic                r_hs;
  logic                r_done;
  logic                aw_hs;
  logic                w_hs;
  logic                w_last_hs;
  logic                b_hs;
  logic                len_bad;

  // Sideband fields and write payload carry no meaning for an error target.
  logic                unused_inputs;
  assign unused_inputs = ^{ARSIZE, ARBURST, AWSIZE, AWBURST, WDATA, WSTRB};

  assign ar_hs     = ARVALID && ARREADY;
  assign r_hs      = RVALID && RREADY;
  assign r_done    = r_hs && RLAST;
  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign w_last_hs = w_hs && WLAST;
  assign b_hs      = BVALID && BREADY;
  assign len_bad   = w_last_hs && (wcnt != wlen);
  assign rcnt_nxt  = rcnt + LEN_ONE;

  assign RDATA = ERR_RDATA;
  assign RRESP = ERR_RESP;
  assign BRESP = ERR_RESP;

  // Read channel control: every output is a register so nothing combinationally
  // follows ARVALID or RREADY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            RID     <= ARID;
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RLAST   <= (ARLEN == '0);
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              RLAST   <= (rcnt_nxt == rlen);
            end
          end
        end
        default: begin
          RVALID  <= 1'b0;
          RLAST   <= 1'b0;
          ARREADY <= 1'b1;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      rlen <= ARLEN;
      rcnt <= '0;
    end else if (r_hs) begin
      rcnt <= rcnt_nxt;
    end
  end

  // Write channel control: address, then data until WLAST, then one response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b1;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            BID     <= AWID;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_last_hs) begin
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_hs) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: begin
          WREADY  <= 1'b0;
          BVALID  <= 1'b0;
          AWREADY <= 1'b1;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // Beat counter wraps naturally at LEN_BITS, so an over-long burst still
  // compares modulo the length field.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      wlen <= AWLEN;
      wcnt <= '0;
    end else if (w_hs) begin
      wcnt <= wcnt + LEN_ONE;
    end
  end

  // Debug statistics; a clear beats any same-cycle increment or mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_err_cnt    <= '0;
      wr_err_cnt    <= '0;
      wlen_mismatch <= 1'b0;
    end else if (err_clr) begin
      rd_err_cnt    <= '0;
      wr_err_cnt    <= '0;
      wlen_mismatch <= 1'b0;
    end else begin
      if (r_done && (rd_err_cnt != CNT_MAX)) begin
        rd_err_cnt <= rd_err_cnt + CNT_ONE;
      end
      if (b_hs && (wr_err_cnt != CNT_MAX)) begin
        wr_err_cnt <= wr_err_cnt + CNT_ONE;
      end
      if (len_bad) begin
        wlen_mismatch <= 1'b1;
      end
    end
  end

  // Write address wins when both channels are accepted together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_err_addr <= '0;
    end else if (aw_hs) begin
      last_err_addr <= AWADDR;
    end else if (ar_hs) begin
      last_err_addr <= ARADDR;
    end
  end

endmodule

// File: tb/tb_axi_err_slave.sv
// Randomized bench for axi_err_slave; a transaction-level model tracks the
// expected counters, sticky flag and captured address.
module tb_axi_err_slave;
  localparam int ID_BITS = 8;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;
  localparam int LEN_BITS = 4;
  localparam int CNT_BITS = 3;
  localparam int MAXC = (1 << CNT_BITS) - 1;
  localparam logic [1:0] ERR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ID_BITS-1:0] ARID = '0, AWID = '0, RID, BID;
  logic [ADDR_BITS-1:0] ARADDR = '0, AWADDR = '0, last_err_addr;
  logic [LEN_BITS-1:0] ARLEN = '0, AWLEN = '0;
  logic [2:0] ARSIZE = '0, AWSIZE = '0;
  logic [1:0] ARBURST = '0, AWBURST = '0, RRESP, BRESP;
  logic ARVALID = 1'b0, ARREADY, RLAST, RVALID, RREADY = 1'b0;
  logic AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
  logic BVALID, BREADY = 1'b0, err_clr = 1'b0, wlen_mismatch;
  logic [DATA_BITS-1:0] RDATA, WDATA = '0;
  logic [DATA_BITS/8-1:0] WSTRB = '0;
  logic [CNT_BITS-1:0] rd_err_cnt, wr_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic exp_mm = 1'b0;
  logic [ADDR_BITS-1:0] exp_addr = '0;

  axi_err_slave #(
    .ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
    .LEN_BITS(LEN_BITS), .ERR_RESP(ERR), .ERR_RDATA('0), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .err_clr(err_clr), .rd_err_cnt(rd_err_cnt), .wr_err_cnt(wr_err_cnt),
    .last_err_addr(last_err_addr), .wlen_mismatch(wlen_mismatch)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ARREADY !== 1'b1) begin n_bad++; $display("FAIL reset_arready: got %b want 1", ARREADY); end
    n_cmp++; if (AWREADY !== 1'b1) begin n_bad++; $display("FAIL reset_awready: got %b want 1", AWREADY); end
    n_cmp++; if (RVALID !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", RVALID); end
    n_cmp++; if (RLAST !== 1'b0) begin n_bad++; $display("FAIL reset_rlast: got %b want 0", RLAST); end
    n_cmp++; if (WREADY !== 1'b0) begin n_bad++; $display("FAIL reset_wready: got %b want 0", WREADY); end
    n_cmp++; if (BVALID !== 1'b0) begin n_bad++; $display("FAIL reset_bvalid: got %b want 0", BVALID); end
    n_cmp++; if (RID !== '0 || BID !== '0) begin n_bad++; $display("FAIL reset_ids: got %h/%h want 0/0", RID, BID); end
    n_cmp++; if (rd_err_cnt !== '0 || wr_err_cnt !== '0) begin n_bad++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", rd_err_cnt, wr_err_cnt); end
    n_cmp++; if (last_err_addr !== '0 || wlen_mismatch !== 1'b0) begin n_bad++; $display("FAIL reset_dbg: got %h/%b want 0/0", last_err_addr, wlen_mismatch); end
  endtask

  // mode 0: RREADY held high, 1: toggled 1,0,1,..., 2: random
  task automatic test_read(input logic [7:0] id, input logic [31:0] addr, input int len, input int mode);
    int cyc;
    int beat;
    cyc = 0;
    while (ARREADY !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    n_cmp++; if (ARREADY !== 1'b1) begin n_bad++; $display("FAIL rd_idle_arready: got %b want 1", ARREADY); end
    ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = 4'(len);
    ARSIZE = 3'($urandom); ARBURST = 2'($urandom); RREADY = 1'b0;
    @(negedge clk);
    ARVALID = 1'b0;
    exp_addr = addr;
    n_cmp++; if (RVALID !== 1'b1) begin n_bad++; $display("FAIL rd_first_latency: rvalid got %b want 1", RVALID); end
    n_cmp++; if (ARREADY !== 1'b0) begin n_bad++; $display("FAIL rd_busy_arready: got %b want 0", ARREADY); end
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 200) begin
      n_cmp++; if (RVALID !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid_beat%0d: got %b want 1", beat, RVALID); end
      n_cmp++; if (RLAST !== (beat == len)) begin n_bad++; $display("FAIL rd_rlast_beat%0d: got %b want %b", beat, RLAST, beat == len); end
      n_cmp++; if (RID !== id || RRESP !== ERR || RDATA !== '0) begin n_bad++; $display("FAIL rd_fields_beat%0d: got %h/%b/%h want %h/%b/0", beat, RID, RRESP, RDATA, id, ERR); end
      if (mode == 0) RREADY = 1'b1;
      else if (mode == 1) RREADY = (cyc % 2 == 0);
      else RREADY = 1'($urandom);
      if (RVALID && RREADY) beat++;
      @(negedge clk);
      cyc++;
    end
    RREADY = 1'b0;
    n_cmp++; if (beat != len + 1) begin n_bad++; $display("FAIL rd_beats: got %0d want %0d", beat, len + 1); end
    if (exp_rd < MAXC) exp_rd++;
    n_cmp++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin n_bad++; $display("FAIL rd_end: rvalid/arready got %b/%b want 0/1", RVALID, ARREADY); end
    n_cmp++; if (rd_err_cnt !== CNT_BITS'(exp_rd)) begin n_bad++; $display("FAIL rd_err_cnt: got %0d want %0d", rd_err_cnt, exp_rd); end
    n_cmp++; if (last_err_addr !== exp_addr) begin n_bad++; $display("FAIL rd_last_addr: got %h want %h", last_err_addr, exp_addr); end
  endtask

  task automatic test_write(input logic [7:0] id, input logic [31:0] addr, input int len, input int nbeats, input int bhold);
    int cyc;
    int beat;
    cyc = 0;
    while (AWREADY !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    n_cmp++; if (AWREADY !== 1'b1) begin n_bad++; $display("FAIL wr_idle_awready: got %b want 1", AWREADY); end
    AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = 4'(len);
    AWSIZE = 3'($urandom); AWBURST = 2'($urandom);
    WVALID = 1'b1; WLAST = 1'b0; WDATA = $urandom;
    n_cmp++; if (WREADY !== 1'b0) begin n_bad++; $display("FAIL wr_early_wready: got %b want 0", WREADY); end
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    exp_addr = addr;
    n_cmp++; if (AWREADY !== 1'b0) begin n_bad++; $display("FAIL wr_busy_awready: got %b want 0", AWREADY); end
    beat = 0; cyc = 0;
    while (beat < nbeats && cyc < 300) begin
      n_cmp++; if (WREADY !== 1'b1 || BVALID !== 1'b0) begin n_bad++; $display("FAIL wr_data_phase_beat%0d: wready/bvalid got %b/%b want 1/0", beat, WREADY, BVALID); end
      WVALID = ($urandom % 4 != 0);
      WLAST = (beat == nbeats - 1);
      WDATA = $urandom; WSTRB = 4'($urandom);
      if (WVALID && WREADY) beat++;
      @(negedge clk);
      cyc++;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    n_cmp++; if (beat != nbeats) begin n_bad++; $display("FAIL wr_beats: got %0d want %0d", beat, nbeats); end
    for (int h = 0; h <= bhold; h++) begin
      n_cmp++; if (BVALID !== 1'b1 || BID !== id || BRESP !== ERR) begin n_bad++; $display("FAIL wr_bresp_hold%0d: got %b/%h/%b want 1/%h/%b", h, BVALID, BID, BRESP, id, ERR); end
      n_cmp++; if (WREADY !== 1'b0) begin n_bad++; $display("FAIL wr_resp_wready: got %b want 0", WREADY); end
      BREADY = (h == bhold);
      @(negedge clk);
    end
    BREADY = 1'b0;
    if (exp_wr < MAXC) exp_wr++;
    if (((nbeats - 1) % (1 << LEN_BITS)) != len) exp_mm = 1'b1;
    n_cmp++; if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin n_bad++; $display("FAIL wr_end: bvalid/awready got %b/%b want 0/1", BVALID, AWREADY); end
    n_cmp++; if (wr_err_cnt !== CNT_BITS'(exp_wr)) begin n_bad++; $display("FAIL wr_err_cnt: got %0d want %0d", wr_err_cnt, exp_wr); end
    n_cmp++; if (wlen_mismatch !== exp_mm) begin n_bad++; $display("FAIL wr_mismatch: got %b want %b", wlen_mismatch, exp_mm); end
    n_cmp++; if (last_err_addr !== exp_addr) begin n_bad++; $display("FAIL wr_last_addr: got %h want %h", last_err_addr, exp_addr); end
  endtask

  task automatic test_concurrent();
    int cyc;
    int rb;
    int wb;
    bit bd;
    n_cmp++; if (ARREADY !== 1'b1 || AWREADY !== 1'b1) begin n_bad++; $display("FAIL cc_ready: got %b/%b want 1/1", ARREADY, AWREADY); end
    ARVALID = 1'b1; ARID = 8'h21; ARADDR = 32'h1000_0010; ARLEN = 4'd1;
    AWVALID = 1'b1; AWID = 8'h42; AWADDR = 32'h2000_0020; AWLEN = 4'd1;
    @(negedge clk);
    ARVALID = 1'b0; AWVALID = 1'b0;
    exp_addr = 32'h2000_0020;
    rb = 0; wb = 0; bd = 1'b0; cyc = 0;
    while (!(rb == 2 && bd) && cyc < 200) begin
      if (rb < 2) begin
        n_cmp++; if (RVALID !== 1'b1 || RLAST !== (rb == 1) || RID !== 8'h21) begin n_bad++; $display("FAIL cc_read_beat%0d: got %b/%b/%h want 1/%b/21", rb, RVALID, RLAST, RID, rb == 1); end
      end else begin
        n_cmp++; if (RVALID !== 1'b0) begin n_bad++; $display("FAIL cc_read_done: rvalid got %b want 0", RVALID); end
      end
      if (wb < 2) begin
        n_cmp++; if (WREADY !== 1'b1) begin n_bad++; $display("FAIL cc_wready_beat%0d: got %b want 1", wb, WREADY); end
      end else if (!bd) begin
        n_cmp++; if (BVALID !== 1'b1 || BID !== 8'h42) begin n_bad++; $display("FAIL cc_bresp: got %b/%h want 1/42", BVALID, BID); end
      end
      RREADY = 1'($urandom);
      WVALID = (wb < 2) ? 1'($urandom) : 1'b0;
      WLAST = (wb == 1);
      BREADY = 1'($urandom);
      if (RVALID && RREADY) rb++;
      if (WVALID && WREADY) wb++;
      if (BVALID && BREADY) bd = 1'b1;
      @(negedge clk);
      cyc++;
    end
    RREADY = 1'b0; WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
    if (exp_rd < MAXC) exp_rd++;
    if (exp_wr < MAXC) exp_wr++;
    n_cmp++; if (rb != 2 || !bd) begin n_bad++; $display("FAIL cc_complete: got rb=%0d bdone=%0d want 2/1", rb, bd); end
    n_cmp++; if (last_err_addr !== exp_addr) begin n_bad++; $display("FAIL cc_last_addr: got %h want %h", last_err_addr, exp_addr); end
    n_cmp++; if (rd_err_cnt !== CNT_BITS'(exp_rd) || wr_err_cnt !== CNT_BITS'(exp_wr)) begin n_bad++; $display("FAIL cc_cnts: got %0d/%0d want %0d/%0d", rd_err_cnt, wr_err_cnt, exp_rd, exp_wr); end
    n_cmp++; if (ARREADY !== 1'b1 || AWREADY !== 1'b1) begin n_bad++; $display("FAIL cc_idle: got %b/%b want 1/1", ARREADY, AWREADY); end
  endtask

  task automatic test_mismatch_clear();
    test_write(8'h33, 32'h6000_0000, 3, 3, 1);
    n_cmp++; if (wlen_mismatch !== 1'b1) begin n_bad++; $display("FAIL mm_flag: got %b want 1", wlen_mismatch); end
    ARVALID = 1'b1; ARID = 8'h44; ARADDR = 32'h6000_0100; ARLEN = 4'd0;
    @(negedge clk);
    ARVALID = 1'b0;
    exp_addr = 32'h6000_0100;
    n_cmp++; if (RVALID !== 1'b1 || RLAST !== 1'b1) begin n_bad++; $display("FAIL mm_read_beat: got %b/%b want 1/1", RVALID, RLAST); end
    RREADY = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    RREADY = 1'b0; err_clr = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_mm = 1'b0;
    n_cmp++; if (rd_err_cnt !== '0 || wr_err_cnt !== '0) begin n_bad++; $display("FAIL clr_cnts: got %0d/%0d want 0/0", rd_err_cnt, wr_err_cnt); end
    n_cmp++; if (wlen_mismatch !== 1'b0) begin n_bad++; $display("FAIL clr_mismatch: got %b want 0", wlen_mismatch); end
    n_cmp++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin n_bad++; $display("FAIL clr_fsm: rvalid/arready got %b/%b want 0/1", RVALID, ARREADY); end
    n_cmp++; if (last_err_addr !== exp_addr) begin n_bad++; $display("FAIL clr_last_addr: got %h want %h", last_err_addr, exp_addr); end
  endtask

  task automatic test_random();
    int len;
    int nb;
    for (int i = 0; i < 20; i++) begin
      len = $urandom_range(0, 7);
      if ($urandom % 2 == 0) begin
        test_read(8'($urandom), $urandom, len, 2);
      end else begin
        nb = ($urandom % 4 == 0) ? $urandom_range(1, 18) : len + 1;
        test_write(8'($urandom), $urandom, len, nb, $urandom_range(0, 3));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    ARVALID = 1'b1; ARID = 8'h77; ARADDR = 32'h3000_0000; ARLEN = 4'd3; RREADY = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (RVALID !== 1'b1 || RLAST !== 1'b0) begin n_bad++; $display("FAIL rstmid_beat2: got %b/%b want 1/0", RVALID, RLAST); end
    RREADY = 1'b0;
    rst = 1'b1;
    #1;
    exp_rd = 0; exp_wr = 0; exp_mm = 1'b0; exp_addr = '0;
    n_cmp++; if (RVALID !== 1'b0 || ARREADY !== 1'b1 || AWREADY !== 1'b1) begin n_bad++; $display("FAIL rstmid_outputs: got %b/%b/%b want 0/1/1", RVALID, ARREADY, AWREADY); end
    n_cmp++; if (rd_err_cnt !== '0 || last_err_addr !== '0 || RLAST !== 1'b0) begin n_bad++; $display("FAIL rstmid_state: got %0d/%h/%b want 0/0/0", rd_err_cnt, last_err_addr, RLAST); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read(8'h5A, 32'h4000_0000, 0, 0);
    test_read(8'hC3, 32'h4000_1000, 3, 1);
    test_write(8'h11, 32'h5000_0000, 7, 8, 3);
    test_concurrent();
    test_mismatch_clear();
    test_random();
    test_reset_mid_burst();
    test_read(8'h78, 32'h3000_0100, 2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
